// File: rtl/pong_pkg.sv
// Shared types for the Pong match sequencer: state encodings and index-width helper.
// Used by match_controller and score_bank; WIN_BY_TWO_EN selects the lead rule in score_bank.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_PAUSE    = 3'd3,
        ST_POINT    = 3'd4,
        ST_LEVEL_UP = 3'd5,
        ST_OVER     = 3'd6
    } match_state_e;

    // Player index width; never below one bit so two players still get a real port.
    function automatic int unsigned player_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/score_bank.sv
// Per-player saturating score counters plus the level-won decision for the current scorer.
// WIN_BY_TWO_EN defined: the scorer must also lead every other player by two.
module score_bank
    import pong_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned SCORE_W       = 4,
    parameter int unsigned POINTS_TO_WIN = 7
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clr,
    input  logic                               inc,
    input  logic [player_idx_w(NUM_PLAYERS)-1:0] inc_idx,
    input  logic [player_idx_w(NUM_PLAYERS)-1:0] chk_idx,
    output logic [NUM_PLAYERS*SCORE_W-1:0]     scores,
    output logic                               level_won_c
);

    localparam int unsigned IW        = player_idx_w(NUM_PLAYERS);
    localparam int unsigned MAX_SCORE = (2 ** SCORE_W) - 1;

    logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
    logic [SCORE_W-1:0] score_d [NUM_PLAYERS];
    logic [SCORE_W-1:0] top_c;

    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            score_d[i] = score_q[i];
            if (clr) begin
                score_d[i] = '0;
            end else if (inc && (inc_idx == IW'(i)) && (score_q[i] != SCORE_W'(MAX_SCORE))) begin
                score_d[i] = score_q[i] + SCORE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_q <= '{default: '0};
        end else begin
            score_q <= score_d;
        end
    end

    always_comb begin
        scores = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            scores[i*SCORE_W +: SCORE_W] = score_q[i];
        end
    end

    // Judged on the registered scores, i.e. the cycle after the increment.
    always_comb begin
        top_c = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (chk_idx == IW'(i)) begin
                top_c = score_q[i];
            end
        end
        level_won_c = (32'(top_c) >= POINTS_TO_WIN);
`ifdef WIN_BY_TWO_EN
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if ((chk_idx != IW'(i)) && ((32'(score_q[i]) + 32'd2) > 32'(top_c))) begin
                level_won_c = 1'b0;
            end
        end
`endif
    end

endmodule

// File: rtl/match_controller.sv
// Pong match sequencer: serve/play/pause/point/level-up/game-over flow with registered outputs.
// WIN_BY_TWO_EN (see score_bank) switches level wins to the two-point-lead rule.
module match_controller
    import pong_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned POINTS_TO_WIN = 7,
    parameter int unsigned MAX_LEVEL     = 7,
    parameter int unsigned SERVE_TICKS   = 60,
    parameter int unsigned SCORE_W       = 4,
    parameter int unsigned LEVEL_W       = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               tick,
    input  logic                               start,
    input  logic                               pause_req,
    input  logic [NUM_PLAYERS-1:0]             point,
    output logic                               game_on,
    output logic                               round_rst,
    output logic [NUM_PLAYERS*SCORE_W-1:0]     score,
    output logic [LEVEL_W-1:0]                 level,
    output logic                               lvl_up,
    output logic                               win,
    output logic [player_idx_w(NUM_PLAYERS)-1:0] winner,
    output logic [2:0]                         state
);

    localparam int unsigned IW    = player_idx_w(NUM_PLAYERS);
    localparam int unsigned CNT_W = $clog2(SERVE_TICKS + 1);

    match_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [IW-1:0]       winner_q, winner_d;
    logic [IW-1:0]       scorer_q, scorer_d;
    logic                pause_q;
    logic                game_on_q, game_on_d;
    logic                round_rst_q, round_rst_d;
    logic                lvl_up_q, lvl_up_d;
    logic                win_q, win_d;
    logic                clr_c, inc_c, level_won_c, pause_rise_c;
    logic [IW-1:0]       low_idx_c;

    score_bank #(
        .NUM_PLAYERS   (NUM_PLAYERS),
        .SCORE_W       (SCORE_W),
        .POINTS_TO_WIN (POINTS_TO_WIN)
    ) u_score_bank (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr_c),
        .inc         (inc_c),
        .inc_idx     (low_idx_c),
        .chk_idx     (scorer_q),
        .scores      (score),
        .level_won_c (level_won_c)
    );

    // Lowest set point bit wins; simultaneous scorers are dropped.
    always_comb begin
        low_idx_c = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (point[i]) begin
                low_idx_c = IW'(i);
            end
        end
    end

    assign pause_rise_c = pause_req & ~pause_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = (state_q == ST_SERVE) ? cnt_q : '0;
        level_d  = level_q;
        winner_d = winner_q;
        scorer_d = scorer_q;
        clr_c    = 1'b0;
        inc_c    = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_SERVE;
                    clr_c   = 1'b1;
                    level_d = LEVEL_W'(1);
                end
            end
            ST_SERVE: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(SERVE_TICKS - 1)) begin
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (|point) begin
                    state_d  = ST_POINT;
                    inc_c    = 1'b1;
                    scorer_d = low_idx_c;
                end else if (pause_rise_c) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_rise_c) begin
                    state_d = ST_PLAY;
                end
            end
            ST_POINT: begin
                if (level_won_c) begin
                    if (level_q == LEVEL_W'(MAX_LEVEL)) begin
                        state_d  = ST_OVER;
                        winner_d = scorer_q;
                    end else begin
                        state_d = ST_LEVEL_UP;
                        level_d = level_q + LEVEL_W'(1);
                        clr_c   = 1'b1;
                    end
                end else begin
                    state_d = ST_SERVE;
                end
            end
            ST_LEVEL_UP: begin
                state_d = ST_SERVE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        game_on_d   = (state_d == ST_PLAY);
        round_rst_d = (state_d == ST_IDLE) || (state_d == ST_SERVE) ||
                      (state_d == ST_LEVEL_UP) || (state_d == ST_OVER);
        lvl_up_d    = (state_d == ST_LEVEL_UP);
        win_d       = (state_d == ST_OVER) && (state_q != ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            level_q     <= LEVEL_W'(1);
            winner_q    <= '0;
            scorer_q    <= '0;
            pause_q     <= 1'b0;
            game_on_q   <= 1'b0;
            round_rst_q <= 1'b1;
            lvl_up_q    <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            winner_q    <= winner_d;
            scorer_q    <= scorer_d;
            pause_q     <= pause_req;
            game_on_q   <= game_on_d;
            round_rst_q <= round_rst_d;
            lvl_up_q    <= lvl_up_d;
            win_q       <= win_d;
        end
    end

    assign game_on   = game_on_q;
    assign round_rst = round_rst_q;
    assign level     = level_q;
    assign lvl_up    = lvl_up_q;
    assign win       = win_q;
    assign winner    = winner_q;
    assign state     = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Randomized directed bench for match_controller against a cycle-level rule model.
// Build with WIN_BY_TWO_EN defined to exercise the two-point-lead rule.
module tb_match_controller;
    import pong_pkg::*;

    localparam int unsigned NP  = 2;
    localparam int unsigned PTW = 7;
    localparam int unsigned ML  = 7;
    localparam int unsigned STK = 60;
    localparam int unsigned SW  = 4;
    localparam int unsigned LW  = 3;
    localparam int unsigned IW  = 1;
    localparam int          BUDGET = 3000;

    logic               clk = 1'b0;
    logic               reset, tick, start, pause_req;
    logic [NP-1:0]      point;
    logic               game_on, round_rst, lvl_up, win;
    logic [NP*SW-1:0]   score;
    logic [LW-1:0]      level;
    logic [IW-1:0]      winner;
    logic [2:0]         state;

    always #5 clk = ~clk;

    match_controller #(
        .NUM_PLAYERS(NP), .POINTS_TO_WIN(PTW), .MAX_LEVEL(ML),
        .SERVE_TICKS(STK), .SCORE_W(SW), .LEVEL_W(LW)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .pause_req(pause_req),
        .point(point), .game_on(game_on), .round_rst(round_rst), .score(score),
        .level(level), .lvl_up(lvl_up), .win(win), .winner(winner), .state(state)
    );

    match_state_e m_st;
    int  m_sc [NP];
    int  m_lvl, m_winner, m_ticks, m_scorer;
    bit  m_prev, m_win;
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_won(input int s);
        bit w = (m_sc[s] >= int'(PTW));
`ifdef WIN_BY_TWO_EN
        for (int o = 0; o < NP; o++) begin
            if (o != s && m_sc[o] + 2 > m_sc[s]) w = 1'b0;
        end
`endif
        return w;
    endfunction

    task automatic model_reset();
        m_st = ST_IDLE; m_lvl = 1; m_winner = 0; m_ticks = 0; m_scorer = 0;
        m_prev = 1'b0; m_win = 1'b0;
        for (int i = 0; i < NP; i++) m_sc[i] = 0;
    endtask

    task automatic model_step();
        bit rise;
        int s;
        rise   = pause_req && !m_prev;
        m_prev = pause_req;
        m_win  = 1'b0;
        case (m_st)
            ST_IDLE, ST_OVER: if (start) begin
                for (int i = 0; i < NP; i++) m_sc[i] = 0;
                m_lvl = 1; m_ticks = 0; m_st = ST_SERVE;
            end
            ST_SERVE: if (tick) begin
                m_ticks++;
                if (m_ticks == int'(STK)) m_st = ST_PLAY;
            end
            ST_PLAY: begin
                if (point != '0) begin
                    s = -1;
                    for (int i = 0; i < NP; i++) if (point[i] && s < 0) s = i;
                    m_sc[s] = (m_sc[s] + 1 > (2 ** SW) - 1) ? (2 ** SW) - 1 : m_sc[s] + 1;
                    m_scorer = s;
                    m_st = ST_POINT;
                end else if (rise) begin
                    m_st = ST_PAUSE;
                end
            end
            ST_PAUSE: if (rise) m_st = ST_PLAY;
            ST_POINT: begin
                if (model_won(m_scorer)) begin
                    if (m_lvl == int'(ML)) begin
                        m_st = ST_OVER; m_winner = m_scorer; m_win = 1'b1;
                    end else begin
                        m_lvl++; m_st = ST_LEVEL_UP;
                        for (int i = 0; i < NP; i++) m_sc[i] = 0;
                    end
                end else begin
                    m_st = ST_SERVE; m_ticks = 0;
                end
            end
            ST_LEVEL_UP: begin m_st = ST_SERVE; m_ticks = 0; end
            default: ;
        endcase
    endtask

    task automatic check_all();
        logic [NP*SW-1:0] esc;
        for (int i = 0; i < NP; i++) esc[i*SW +: SW] = SW'(m_sc[i]);
        check("state", 32'(state), 32'(m_st));
        check("game_on", 32'(game_on), 32'(m_st == ST_PLAY));
        check("round_rst", 32'(round_rst), 32'(m_st == ST_IDLE || m_st == ST_SERVE ||
                                                m_st == ST_LEVEL_UP || m_st == ST_OVER));
        check("score", 32'(score), 32'(esc));
        check("level", 32'(level), 32'(m_lvl));
        check("lvl_up", 32'(lvl_up), 32'(m_st == ST_LEVEL_UP));
        check("win", 32'(win), 32'(m_win));
        check("winner", 32'(winner), 32'(m_winner));
    endtask

    task automatic cyc(input bit tk, input bit st, input bit pz, input logic [NP-1:0] pt);
        tick = tk; start = st; pause_req = pz; point = pt;
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        #1;
        check_all();
    endtask

    // Run serve ticks (random density, random ignored start) until play resumes or the match ends.
    task automatic to_play();
        int n = 0;
        while (m_st != ST_PLAY && m_st != ST_OVER && m_st != ST_IDLE && n < BUDGET) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'b0, '0);
            n++;
        end
        check("to_play_budget", 32'(n < BUDGET), 32'd1);
    endtask

    task automatic score_pt(input logic [NP-1:0] m);
        cyc(1'b0, 1'b0, 1'b0, m);
        to_play();
    endtask

    initial begin
        int n;
        logic [NP-1:0] m;
        reset = 1'b1; tick = 1'b0; start = 1'b0; pause_req = 1'b0; point = '0;
        model_reset();
        cyc(1'b1, 1'b1, 1'b1, 2'b11);
        cyc(1'b0, 1'b0, 1'b0, '0);
        reset = 1'b0;
        check("reset_state", 32'(state), 32'(ST_IDLE));
        check("reset_round_rst", 32'(round_rst), 32'd1);
        check("reset_level", 32'(level), 32'd1);

        cyc(1'b0, 1'b1, 1'b0, '0);
        to_play();
        check("first_play", 32'(game_on), 32'd1);

        // Player 1 takes level 1.
        repeat (7) score_pt(2'b10);
        check("p1_level2", 32'(level), 32'd2);
        check("p1_scores_clear", 32'(score), 32'd0);

        // Simultaneous scorers with a pause edge in the same cycle.
        cyc(1'b0, 1'b0, 1'b1, 2'b11);
        check("dual_state", 32'(state), 32'(ST_POINT));
        check("dual_p0", 32'(score[SW-1:0]), 32'd1);
        check("dual_p1", 32'(score[2*SW-1:SW]), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        to_play();

        // Held pause button: one entry, points and ticks frozen out.
        cyc(1'b0, 1'b0, 1'b1, '0);
        check("pause_enter", 32'(state), 32'(ST_PAUSE));
        repeat (100) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 1'b1,
                         2'($urandom_range(0, 3)));
        check("pause_held", 32'(state), 32'(ST_PAUSE));
        check("pause_game_on", 32'(game_on), 32'd0);
        check("pause_round_rst", 32'(round_rst), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'b01);
        cyc(1'b0, 1'b0, 1'b1, '0);
        check("unpause", 32'(state), 32'(ST_PLAY));
        cyc(1'b0, 1'b0, 1'b0, '0);

        // Random rallies to match end; player 0 forced to score at the last level.
        n = 0;
        while (m_st != ST_OVER && n < BUDGET) begin
            m = 2'($urandom_range(1, 3));
            if (m_lvl == int'(ML)) m = m | 2'b01;
            score_pt(m);
            n++;
        end
        check("over_state", 32'(state), 32'(ST_OVER));
        check("over_winner", 32'(winner), 32'd0);
        check("over_level", 32'(level), 32'(ML));
        repeat (5) cyc($urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 1) == 1,
                       2'($urandom_range(0, 3)));
        check("over_hold", 32'(state), 32'(ST_OVER));

        cyc(1'b0, 1'b1, 1'b0, '0);
        check("restart_level", 32'(level), 32'd1);
        check("restart_score", 32'(score), 32'd0);

        // Reset in the middle of a serve clears the tick counter.
        repeat (20) cyc(1'b1, 1'b0, 1'b0, '0);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, '0);
        reset = 1'b0;
        check("midserve_reset", 32'(state), 32'(ST_IDLE));
        cyc(1'b0, 1'b1, 1'b0, '0);
        repeat (STK - 1) cyc(1'b1, 1'b0, 1'b0, '0);
        check("serve_59", 32'(game_on), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        check("serve_60", 32'(game_on), 32'd1);

        // 6-6 then player 0 scores.
        repeat (6) score_pt(2'b01);
        repeat (6) score_pt(2'b10);
        score_pt(2'b01);
`ifdef WIN_BY_TWO_EN
        check("deuce_7_6", 32'(level), 32'd1);
        score_pt(2'b10);
        score_pt(2'b01);
        score_pt(2'b01);
        check("deuce_9_7", 32'(level), 32'd2);
`else
        check("first_to_7", 32'(level), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
